// File: rtl/genius_defs.sv
// genius_defs: state codes shared by the LED sequencer and its hex debug output
package genius_defs;
  localparam logic [3:0] OCIOSO  = 4'd0;
  localparam logic [3:0] CARREGA = 4'd1;
  localparam logic [3:0] MOSTRA  = 4'd2;
  localparam logic [3:0] APAGA   = 4'd3;
  localparam logic [3:0] FIM     = 4'd4;
endpackage

// File: rtl/contador_tempo.sv
// contador_tempo: 16-bit dwell timer, wraps at modulus M, flags when it reaches limite
// Ports: clock; zera clears (priority); conta advances; limite is the compare value; fim is high while count == limite.
module contador_tempo #(
  parameter int M = 65536
) (
  input  logic        clock,
  input  logic        zera,
  input  logic        conta,
  input  logic [15:0] limite,
  output logic        fim
);
  logic [15:0] r_q;
  always_ff @(posedge clock)
    if (zera) r_q <= '0;
    else if (conta) r_q <= (r_q == 16'(M - 1)) ? '0 : r_q + 16'd1;
  assign fim = r_q == limite;
endmodule

// File: rtl/sequenciador_leds.sv
// sequenciador_leds: plays memory items 0..rodada on the LEDs with on/off dwell times
// Ports: clock, reset (sync, active-high); iniciar starts from OCIOSO; parar aborts;
// rodada is the last item index; dado_mem is sync-read data for endereco;
// leds shows the item only in MOSTRA; ocupado is high outside OCIOSO; pronto pulses in FIM;
// db_estado is the raw state code.
module sequenciador_leds
  import genius_defs::*;
#(
  parameter int T_ON  = 50,
  parameter int T_OFF = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic [3:0] rodada,
  input  logic [3:0] dado_mem,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);
  localparam int M = (T_ON > T_OFF) ? T_ON : T_OFF;
  logic [3:0]  r_estado, r_rodada, r_end, w_prox;
  logic [15:0] w_limite;
  logic        w_fim, w_ultimo, w_zera;
  assign w_limite = (r_estado == MOSTRA) ? 16'(T_ON - 1) : 16'(T_OFF - 1);
  assign w_ultimo = r_end == r_rodada;
  always_comb begin
    w_prox = parar                  ? OCIOSO :
             (r_estado == OCIOSO)   ? (iniciar ? CARREGA : OCIOSO) :
             (r_estado == CARREGA)  ? MOSTRA :
             (r_estado == MOSTRA)   ? (w_fim ? APAGA : MOSTRA) :
             (r_estado == APAGA)    ? (w_fim ? (w_ultimo ? FIM : CARREGA) : APAGA) :
                                      OCIOSO;
  end
  // The timer only runs in the two dwell states and restarts on every state change.
  assign w_zera = reset || (w_prox != r_estado) || !(r_estado == MOSTRA || r_estado == APAGA);
  contador_tempo #(.M(M)) u_tempo (
    .clock (clock),
    .zera  (w_zera),
    .conta (1'b1),
    .limite(w_limite),
    .fim   (w_fim)
  );
  always_ff @(posedge clock)
    if (reset) begin
      r_estado <= OCIOSO;
      r_rodada <= '0;
      r_end    <= '0;
    end else begin
      r_estado <= w_prox;
      if (r_estado == OCIOSO && iniciar && !parar) r_rodada <= rodada;
      if (parar || (r_estado == OCIOSO && iniciar)) r_end <= '0;
      else if (r_estado == APAGA && w_fim && !w_ultimo) r_end <= r_end + 4'd1;
    end
  assign endereco  = r_end;
  assign leds      = (r_estado == MOSTRA) ? dado_mem : 4'b0000;
  assign ocupado   = r_estado != OCIOSO;
  assign pronto    = r_estado == FIM;
  assign db_estado = r_estado;
endmodule

// File: doc/sequenciador_leds.md
SEQUENCIADOR_LEDS -- requirements
Module: sequenciador_leds

Interface
REQ-001 SHALL have parameter T_ON, default 50, LED-on time per sequence item in clock cycles (legal range 1..65535).
REQ-002 SHALL have parameter T_OFF, default 25, LED-off gap after each item in clock cycles (legal range 1..65535).
REQ-003 clock  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 iniciar  input  1  start-playback request, sampled only in OCIOSO.
REQ-006 parar  input  1  synchronous abort of playback.
REQ-007 rodada  input  4  index of last item to play (plays addresses 0..rodada).
REQ-008 dado_mem  input  4  memory read data, valid one cycle after endereco changes (synchronous read).
REQ-009 endereco  output  4  memory read address.
REQ-010 leds  output  4  LED drive, one-hot pattern from memory or 0000.
REQ-011 ocupado  output  1  high in every state except OCIOSO.
REQ-012 pronto  output  1  single-cycle pulse on playback completion.
REQ-013 db_estado  output  4  current state code for the hex display.

Function
REQ-014 States and codes SHALL be OCIOSO=0, CARREGA=1, MOSTRA=2, APAGA=3, FIM=4; codes 5..15 unused and SHALL map to OCIOSO on the next edge.
REQ-015 OCIOSO: with iniciar=1, SHALL latch rodada into rodada_reg, set endereco=0 and go to CARREGA; otherwise stay.
REQ-016 CARREGA: SHALL last exactly 1 cycle with leds=0000 and the timer cleared, then go to MOSTRA.
REQ-017 MOSTRA: SHALL drive leds=dado_mem for exactly T_ON cycles, then go to APAGA with the timer cleared.
REQ-018 APAGA: SHALL drive leds=0000 for exactly T_OFF cycles; at the end, go to FIM if endereco==rodada_reg, else increment endereco and go to CARREGA.
REQ-019 FIM: SHALL assert pronto for exactly 1 cycle with leds=0000, then go to OCIOSO.
REQ-020 From the first CARREGA cycle to the FIM cycle SHALL take exactly (rodada_reg+1)*(1+T_ON+T_OFF) cycles.
REQ-021 leds SHALL be 0000 in every state except MOSTRA.
REQ-022 iniciar SHALL be ignored while ocupado=1; rodada changes after latching SHALL have no effect.
REQ-023 rodada=15 SHALL play all 16 addresses; endereco SHALL never wrap past rodada_reg.
REQ-024 parar=1 in any non-OCIOSO state SHALL force OCIOSO on the next edge, with endereco=0 and leds=0000; pronto SHALL NOT pulse.
REQ-025 If parar and iniciar are both high in OCIOSO, parar SHALL win and the state SHALL remain OCIOSO.
REQ-026 Timer width SHALL be 16 bits; the timer SHALL be cleared on every state entry.

Reset
REQ-027 reset=1 at a clock edge SHALL set state=OCIOSO, endereco=0, rodada_reg=0, timer=0, leds=0000, pronto=0, ocupado=0 and db_estado=0, and SHALL take priority over all other inputs.
REQ-028 reset asserted mid-playback SHALL abort without a pronto pulse.

Structure
REQ-029 State codes SHALL live in a shared package or include file (genius_defs) so the top level and the hex debug path share one definition.
REQ-030 The dwell timer SHALL be one sub-module instance, contador_tempo, with zera, conta and fim ports, parameterised by modulus.
REQ-031 Outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from iniciar to leds.

Verification
REQ-032 Bench runs with T_ON=4, T_OFF=2, and a memory model mem[0..3]=0001,0010,0100,1000.
REQ-033 rodada=0, iniciar pulse -> CARREGA at cycle 1, leds=0001 in cycles 2-5, leds=0000 in cycles 6-7, pronto=1 only in cycle 8.
REQ-034 rodada=2 -> leds shows 0001, 0010, 0100 in that order; pronto=1 in cycle 22; endereco never exceeds 2.
REQ-035 rodada=15 with the memory filled -> 16 items played, pronto in cycle 113, endereco ends at 15 with no wrap.
REQ-036 parar during the second MOSTRA (rodada=3) -> next cycle state=0, leds=0000, ocupado=0, and no pronto pulse for 10 following cycles.
REQ-037 iniciar re-pulsed and rodada changed to 1 mid-playback of rodada=3 -> playback unaffected, 4 items played, single pronto pulse.
REQ-038 reset asserted in APAGA -> next cycle all outputs 0; subsequent iniciar with rodada=0 -> normal 8-cycle sequence.
